// File: rtl/ram4k_arbiter.sv
// ram4k_arbiter: zero-fills a RAM4K after reset, then round-robin shares its single port between A and B
// Ports:
//   clk, rst_n                                 clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata -> a_gnt         requester A access (grant is combinational)
//   a_rvalid/a_rdata                           A read return, one cycle after grant
//   b_*                                        same as A, for requester B
//   ram_in/ram_load/ram_address <- ram_out     RAM4K port
//   busy                                       high while the clear sequence runs
module ram4k_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  output logic [AW-1:0]    ram_address,
  input  logic [WIDTH-1:0] ram_out,
  output logic             busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic ptr;
  logic clr, run;
  // ptr=0 favours A, ptr=1 favours B; combinational outputs are gated by rst_n
  always_comb begin
    state_nx = state;
    clr = rst_n && state == CLEAR;
    run = rst_n && state == RUN;
    if (state == CLEAR && clr_cnt == '1) state_nx = RUN;
    a_gnt = run && a_req && (!b_req || !ptr);
    b_gnt = run && b_req && (!a_req || ptr);
    busy = clr;
    ram_load = clr || (a_gnt && a_we) || (b_gnt && b_we);
    ram_address = clr ? clr_cnt : a_gnt ? a_addr : b_gnt ? b_addr : '0;
    ram_in = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt <= '0;
      ptr <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state <= state_nx;
      clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
      if (a_gnt) ptr <= 1'b1;
      else if (b_gnt) ptr <= 1'b0;
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= ram_out;
      if (b_gnt && !b_we) b_rdata <= ram_out;
    end
  end
endmodule

// File: tb/tb_ram4k_arbiter.sv
// tb_ram4k_arbiter: randomized check of ram4k_arbiter against a behavioural memory/arbitration model
module tb_ram4k_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, a_req, a_we, b_req, b_we, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_load, busy;
  logic [11:0] a_addr, b_addr, ram_address;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_in, ram_out;
  logic [15:0] mem [4096];
  logic rst1_n, a_req1, a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, ram_load1, busy1;
  logic [11:0] ram_address1;
  logic [15:0] a_rdata1, b_rdata1, ram_in1, ram_out1;
  logic [15:0] mem1 [4096];
  ram4k_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out), .busy(busy)
  );
  ram4k_arbiter #(.CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .a_req(a_req1), .a_we(1'b0), .a_addr(12'd5), .a_wdata(16'h0),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(1'b0), .b_we(1'b0), .b_addr(12'd0), .b_wdata(16'h0),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .ram_in(ram_in1), .ram_load(ram_load1), .ram_address(ram_address1),
    .ram_out(ram_out1), .busy(busy1)
  );
  assign ram_out = mem[ram_address];
  assign ram_out1 = mem1[ram_address1];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  always @(posedge clk) if (ram_load1) mem1[ram_address1] <= ram_in1;
  int vectors = 0, miscompares = 0;
  logic [15:0] m_mem [4096];
  logic m_prio_b, e_arv, e_brv, ga, gb;
  logic [15:0] e_ard, e_brd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_reset();
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_ram_load", ram_load, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_in", ram_in, 0);
    check("rst_busy", busy, 0);
  endtask
  task automatic model_reset();
    m_prio_b = 1'b0;
    e_arv = 1'b0;
    e_brv = 1'b0;
    e_ard = '0;
    e_brd = '0;
  endtask
  task automatic clear_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("clr_busy", busy, 1);
      check("clr_load", ram_load, 1);
      check("clr_addr", ram_address, i);
      check("clr_in", ram_in, 0);
      check("clr_a_gnt", a_gnt, 0);
      @(posedge clk);
    end
    #1;
    for (int i = 0; i < 4096; i++) m_mem[i] = '0;
    e_arv = 1'b0;
    e_brv = 1'b0;
  endtask
  task automatic run_cycle();
    logic wa, wb;
    @(negedge clk);
    wa = a_req && (!b_req || !m_prio_b);
    wb = b_req && !wa;
    check("a_gnt", a_gnt, wa);
    check("b_gnt", b_gnt, wb);
    check("a_rvalid", a_rvalid, e_arv);
    check("b_rvalid", b_rvalid, e_brv);
    check("a_rdata", a_rdata, e_ard);
    check("b_rdata", b_rdata, e_brd);
    check("busy", busy, 0);
    check("ram_load", ram_load, (wa && a_we) || (wb && b_we));
    check("ram_address", ram_address, wa ? a_addr : wb ? b_addr : 12'd0);
    check("ram_in", ram_in, wa ? a_wdata : wb ? b_wdata : 16'd0);
    e_arv = wa && !a_we;
    e_brv = wb && !b_we;
    if (e_arv) e_ard = m_mem[a_addr];
    if (e_brv) e_brd = m_mem[b_addr];
    if (wa && a_we) m_mem[a_addr] = a_wdata;
    if (wb && b_we) m_mem[b_addr] = b_wdata;
    if (wa) m_prio_b = 1'b1;
    else if (wb) m_prio_b = 1'b0;
    ga = wa;
    gb = wb;
    @(posedge clk);
    #1;
    if (wa) a_req = 1'b0;
    if (wb) b_req = 1'b0;
  endtask
  task automatic issue_a(input logic we, input logic [11:0] addr, input logic [15:0] data, output int n);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    n = 0;
    do begin run_cycle(); n++; end while (!ga && n < 10);
    if (!ga) check("a_grant_timeout", 0, 1);
  endtask
  task automatic issue_b(input logic we, input logic [11:0] addr, input logic [15:0] data, output int n);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    n = 0;
    do begin run_cycle(); n++; end while (!gb && n < 10);
    if (!gb) check("b_grant_timeout", 0, 1);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 4096; i++) begin mem[i] = 16'($urandom); mem1[i] = 16'($urandom); end
    rst_n = 1'b0; rst1_n = 1'b0; a_req1 = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'd0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 12'd0; b_wdata = '0;
    model_reset();
    #3;
    check_reset();
    check("rst1_a_gnt", a_gnt1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_check(4096);
    n = 0;
    do begin run_cycle(); n++; end while (!ga && n < 10);
    check("clr_wait_gnt_cycles", n, 1);
    issue_a(1'b0, 12'd1234, 16'h0, n);
    issue_a(1'b0, 12'd4095, 16'h0, n);
    run_cycle();
    check("rd_4095_zero", a_rdata, 16'h0000);
    issue_a(1'b1, 12'h123, 16'hBEEF, n);
    issue_a(1'b0, 12'h123, 16'h0, n);
    check("beef_rd_gnt_cycles", n, 1);
    run_cycle();
    check("beef_rdata", a_rdata, 16'hBEEF);
    issue_b(1'b1, 12'hFFF, 16'h5555, n);
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'hFFF;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h123;
    run_cycle();
    check("ptr_after_b_a_first", ga, 1);
    run_cycle();
    check("ptr_then_b", gb, 1);
    check("a_rd_5555", a_rdata, 16'h5555);
    run_cycle();
    check("b_rd_beef", b_rdata, 16'hBEEF);
    for (int c = 0; c < 1500; c++) begin
      if (!a_req && $urandom_range(0, 9) < 6) begin
        a_req = 1'b1; a_we = 1'($urandom); a_wdata = 16'($urandom);
        a_addr = $urandom_range(0, 3) == 0 ? 12'($urandom) : 12'($urandom_range(0, 15));
      end
      if (!b_req && $urandom_range(0, 9) < 6) begin
        b_req = 1'b1; b_we = 1'($urandom); b_wdata = 16'($urandom);
        b_addr = $urandom_range(0, 3) == 0 ? 12'($urandom) : 12'($urandom_range(0, 15));
      end
      run_cycle();
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'd7;
    b_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_check(100);
    rst_n = 1'b0;
    #1;
    check_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_check(4096);
    for (int c = 0; c < 8; c++) begin
      if (!a_req) begin a_req = 1'b1; a_we = 1'b0; a_addr = 12'($urandom); end
      if (!b_req) begin b_req = 1'b1; b_we = 1'b0; b_addr = 12'($urandom); end
      run_cycle();
      check("contend_alt_a", ga, (c % 2) == 0);
    end
    a_req = 1'b0; b_req = 1'b0;
    run_cycle();
    rst1_n = 1'b1;
    @(negedge clk);
    check("nc_first_gnt", a_gnt1, 1);
    check("nc_busy", busy1, 0);
    @(posedge clk); #1;
    a_req1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("nc_busy_run", busy1, 0);
      check("nc_rvalid", a_rvalid1, c == 0);
      @(posedge clk); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram4k_arbiter.md
# ram4k_arbiter

Sequencer and two-port arbiter in front of a single RAM4K instance (16-bit words, 4096 entries, combinational read, write on rising clock edge). After reset it zero-fills the whole RAM. It then shares the RAM's single port between requester A (CPU data side) and requester B (DMA/screen refresh side) with round-robin arbitration. Read data is returned one cycle after grant.

## Interface
Parameters:
- WIDTH, 16, data word width; must match RAM4K.
- AW, 12, address width; RAM depth is 2**AW.
- CLEAR_ON_RESET, 1, 1: zero-fill the RAM after reset; 0: go straight to RUN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req  in  1  A requests an access; held with fields stable until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  AW  A word address.
- a_wdata  in  WIDTH  A write data.
- a_gnt  out  1  combinational; the access is performed at this clock edge.
- a_rvalid  out  1  registered; A read data valid, one-cycle pulse.
- a_rdata  out  WIDTH  registered; A read data, holds until the next A read.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A signals, for requester B.
- ram_in  out  WIDTH  to RAM4K in.
- ram_load  out  1  to RAM4K load.
- ram_address  out  AW  to RAM4K address.
- ram_out  in  WIDTH  from RAM4K out.
- busy  out  1  high while the clear sequence runs.

## Operation
- States: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR:
  - ram_load=1, ram_address=clr_cnt, ram_in=0, busy=1, both grants 0.
  - clr_cnt increments by 1 each cycle from 0.
  - On the cycle clr_cnt=2**AW-1, the write completes; the next state is RUN and clr_cnt wraps to 0.
- RUN arbitration:
  - One-bit priority pointer ptr, reset value A.
  - Only one side requesting: that side is granted.
  - Both sides requesting: the ptr side is granted.
  - After any grant, ptr points to the non-granted side.
  - No request: ptr is unchanged.
- RUN datapath:
  - ram_address = granted addr; ram_in = granted wdata; ram_load = gnt & we.
  - No grant: ram_address=0, ram_in=0, ram_load=0.
- Read, granted side X:
  - At the grant edge, X_rdata <= ram_out.
  - X_rvalid=1 for exactly the following cycle.
  - A write grant does not pulse rvalid and does not change rdata.
- Simultaneous same-address write by one side and read by the other: impossible, because only one side is granted per cycle. A read granted in the cycle after a write to the same address returns the new data.
- Reset mid-operation:
  - Asserting rst_n low at any time forces outputs to their reset values immediately.
  - On release the block restarts from state entry: a full clear when CLEAR_ON_RESET=1. A partial clear is never resumed.

## Timing
- Reset values, held while rst_n=0:
  - a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - ram_load=0, ram_address=0, ram_in=0.
  - busy=0; it rises on the first cycle after release when CLEAR_ON_RESET=1.
  - Combinational outputs are gated by rst_n.
- Clear duration is exactly 2**AW cycles (4096 by default). The first grant is possible on cycle 4096 counting the first edge after release as cycle 0.
- Grant latency: 0 cycles (same-cycle combinational grant while in RUN). Read data latency: 1 cycle after grant.
- Throughput: one access per cycle total. Under continuous contention, each side gets every other cycle.
- Requests asserted during CLEAR wait, with no grant and no loss, until RUN.

## Test plan
- Reset, CLEAR_ON_RESET=1, no requests:
  - busy=1 for exactly 4096 cycles, ram_load=1 throughout, ram_address walks 0..4095, then busy=0.
  - A reads of addresses 0, 1234 and 4095 return 0x0000.
- A writes 0xBEEF to 0x123, then A reads 0x123 on the next cycle:
  - a_gnt on both cycles.
  - a_rvalid one cycle later with a_rdata=0xBEEF; b_rvalid stays 0.
- A and B request reads continuously from the first RUN cycle:
  - Grants alternate A, B, A, B…, starting with A.
  - Each rvalid pulses one cycle after its grant.
- B writes 0x5555 to 0xFFF while A idles; then A and B request simultaneously:
  - A is granted first (ptr moved to A after B's grant).
- rst_n pulsed low for 1 cycle during CLEAR at clr_cnt=100:
  - Outputs drop to reset values immediately.
  - Clear restarts from address 0 and lasts a full 4096 cycles.
- CLEAR_ON_RESET=0:
  - busy never asserts.
  - A request held at reset release is granted on the first cycle after release.
